bip_debug_ctrl: RTL and testbench

- Debug/run controller between the UART (rx/tx byte interfaces) and the BIP processor core inside Main.
- Decodes command bytes received over UART.
- Starts, single-steps or resets the BIP, counts executed cycles and snapshots PC and ACC when the core stops.
- Streams the snapshot back through the UART transmitter, one byte per handshake, and drives the status LED.

---
 rtl/bip_dbg_pkg.sv | 34 +++
 rtl/bip_dbg_frame_mux.sv | 36 +++
 rtl/bip_debug_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_bip_debug_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bip_dbg_pkg.sv
// -----------------------------------------------------------------------------
// bip_dbg_pkg
// Shared definitions for the BIP debug/run controller.
//   - dbg_state_e : controller FSM states
//   - CMD_*       : UART command byte values
//   - FRAME_LEN   : number of bytes in the reply frame
//   - snap_t      : snapshot layout (PC, ACC, cycle count; 16 bits each)
// -----------------------------------------------------------------------------
package bip_dbg_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RUN  = 3'd1,
        STEP = 3'd2,
        SNAP = 3'd3,
        SEND = 3'd4,
        WAIT = 3'd5
    } dbg_state_e;

    localparam logic [7:0] CMD_RUN  = 8'h01;
    localparam logic [7:0] CMD_STEP = 8'h02;
    localparam logic [7:0] CMD_RST  = 8'h03;

    localparam int unsigned FRAME_LEN = 6;
    localparam logic [2:0]  LAST_IDX  = 3'(FRAME_LEN - 1);

    // Field order matches the reply frame order: PC first, count last.
    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] acc;
        logic [15:0] cnt;
    } snap_t;

endpackage

// File: rtl/bip_dbg_frame_mux.sv
// -----------------------------------------------------------------------------
// bip_dbg_frame_mux
// Combinational byte selector for the 6-byte reply frame. Each 16-bit field
// is sent MSB first: PC hi, PC lo, ACC hi, ACC lo, CNT hi, CNT lo.
// Ports:
//   snap_i [47:0] : latched snapshot {pc, acc, cnt}
//   idx_i  [2:0]  : byte index 0..5
//   byte_o [7:0]  : selected frame byte (0 for out-of-range index)
// -----------------------------------------------------------------------------
module bip_dbg_frame_mux
    import bip_dbg_pkg::*;
(
    input  logic [47:0] snap_i,
    input  logic [2:0]  idx_i,
    output logic [7:0]  byte_o
);

    snap_t snap_s;

    assign snap_s = snap_t'(snap_i);

    // Select one frame byte by index.
    always_comb begin
        byte_o = 8'h00;
        case (idx_i)
            3'd0:    byte_o = snap_s.pc[15:8];
            3'd1:    byte_o = snap_s.pc[7:0];
            3'd2:    byte_o = snap_s.acc[15:8];
            3'd3:    byte_o = snap_s.acc[7:0];
            3'd4:    byte_o = snap_s.cnt[15:8];
            3'd5:    byte_o = snap_s.cnt[7:0];
            default: byte_o = 8'h00;
        endcase
    end

endmodule

// File: rtl/bip_debug_ctrl.sv
// -----------------------------------------------------------------------------
// bip_debug_ctrl
// Debug/run controller sitting between the UART byte interfaces and the BIP
// core. Decodes command bytes, runs or single-steps the core, counts enabled
// cycles, snapshots PC/ACC/count when the core stops and streams the snapshot
// back through the UART transmitter one byte per handshake.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   rx_done, rx_data    : received-byte pulse and byte
//   tx_done             : transmitter finished current byte
//   tx_start, tx_data   : launch pulse and byte (held until tx_done)
//   bip_halt            : core decodes HLT (meaningful while bip_en=1)
//   bip_pc, bip_acc     : core program counter and accumulator
//   bip_en              : registered clock-enable for the core
//   bip_rst             : one-cycle reset pulse for the core
//   led                 : high while running
// -----------------------------------------------------------------------------
module bip_debug_ctrl #(
    parameter int PC_W   = 11,
    parameter int DATA_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_done,
    input  logic [7:0]        rx_data,
    input  logic              tx_done,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    input  logic              bip_halt,
    input  logic [PC_W-1:0]   bip_pc,
    input  logic [DATA_W-1:0] bip_acc,
    output logic              bip_en,
    output logic              bip_rst,
    output logic              led
);

    import bip_dbg_pkg::*;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    dbg_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    snap_t            snap_q, snap_d;
    logic [2:0]       idx_q, idx_d;
    logic             tx_start_q, tx_start_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             bip_en_q, bip_en_d;
    logic             bip_rst_q, bip_rst_d;
    logic             led_q, led_d;

    logic [15:0]      pc_ext_s;
    logic [15:0]      acc_ext_s;
    logic [15:0]      cnt_ext_s;
    logic             halt_seen_s;
    logic [7:0]       frame_byte_s;

    // A halt only counts when the core actually executed that cycle.
    assign halt_seen_s = bip_en_q && bip_halt;

    // Zero-extend core values and the counter to the 16-bit frame fields.
    always_comb begin
        pc_ext_s                = 16'h0000;
        acc_ext_s               = 16'h0000;
        cnt_ext_s               = 16'h0000;
        pc_ext_s[PC_W-1:0]      = bip_pc;
        acc_ext_s[DATA_W-1:0]   = bip_acc;
        cnt_ext_s[CNT_W-1:0]    = cnt_q;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (rx_done && (rx_data == CMD_RUN)) begin
                    state_d = RUN;
                end else if (rx_done && (rx_data == CMD_STEP)) begin
                    state_d = STEP;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (halt_seen_s) begin
                    state_d = SNAP;
                end else begin
                    state_d = RUN;
                end
            end
            STEP:    state_d = SNAP;
            SNAP:    state_d = SEND;
            SEND:    state_d = WAIT;
            WAIT: begin
                if (tx_done) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = IDLE;
                    end else begin
                        state_d = SEND;
                    end
                end else begin
                    state_d = WAIT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath and output next values.
    always_comb begin
        cnt_d     = cnt_q;
        snap_d    = snap_q;
        idx_d     = idx_q;
        bip_rst_d = 1'b0;
        bip_en_d  = 1'b0;

        // Every executed core cycle is counted, saturating at the maximum.
        if (bip_en_q && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end

        case (state_q)
            IDLE: begin
                if (rx_done && ((rx_data == CMD_RUN) || (rx_data == CMD_RST))) begin
                    bip_rst_d = 1'b1;
                    cnt_d     = '0;
                end else if (rx_done && (rx_data == CMD_STEP)) begin
                    // Enable lands in the STEP state cycle: exactly one core cycle.
                    bip_en_d  = 1'b1;
                end else begin
                    bip_en_d  = 1'b0;
                end
            end
            RUN: begin
                // First RUN cycle coincides with bip_rst, so enable follows it.
                bip_en_d = !halt_seen_s;
            end
            STEP: begin
                bip_en_d = 1'b0;
            end
            SNAP: begin
                snap_d.pc  = pc_ext_s;
                snap_d.acc = acc_ext_s;
                snap_d.cnt = cnt_ext_s;
                idx_d      = 3'd0;
            end
            WAIT: begin
                if (tx_done && (idx_q != LAST_IDX)) begin
                    idx_d = idx_q + 3'd1;
                end else begin
                    idx_d = idx_q;
                end
            end
            default: begin
                bip_en_d = 1'b0;
            end
        endcase
    end

    // Outputs derived from the next state so they line up with state_q.
    always_comb begin
        tx_start_d = (state_d == SEND);
        led_d      = (state_d == RUN);
        if (tx_start_d) begin
            tx_data_d = frame_byte_s;
        end else begin
            tx_data_d = tx_data_q;
        end
    end

    // Looks at the next snapshot/index so the byte is ready with tx_start.
    bip_dbg_frame_mux u_frame_mux (
        .snap_i (snap_d),
        .idx_i  (idx_d),
        .byte_o (frame_byte_s)
    );

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q      <= '0;
            snap_q     <= '0;
            idx_q      <= 3'd0;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
            bip_en_q   <= 1'b0;
            bip_rst_q  <= 1'b0;
            led_q      <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            snap_q     <= snap_d;
            idx_q      <= idx_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            bip_en_q   <= bip_en_d;
            bip_rst_q  <= bip_rst_d;
            led_q      <= led_d;
        end
    end

    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;
    assign bip_en   = bip_en_q;
    assign bip_rst  = bip_rst_q;
    assign led      = led_q;

endmodule

// File: tb/tb_bip_debug_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bip_debug_ctrl
// Directed self-checking bench for bip_debug_ctrl. Inputs change 1 time unit
// after the rising edge; outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_bip_debug_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx_done;
    logic [7:0]  rx_data;
    logic        tx_done;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        bip_halt;
    logic [10:0] bip_pc;
    logic [15:0] bip_acc;
    logic        bip_en;
    logic        bip_rst;
    logic        led;

    int compared   = 0;
    int mismatched = 0;

    bip_debug_ctrl #(
        .PC_W   (11),
        .DATA_W (16),
        .CNT_W  (16)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rx_done  (rx_done),
        .rx_data  (rx_data),
        .tx_done  (tx_done),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .bip_halt (bip_halt),
        .bip_pc   (bip_pc),
        .bip_acc  (bip_acc),
        .bip_en   (bip_en),
        .bip_rst  (bip_rst),
        .led      (led)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic outs(input string tag, input logic en, input logic rst,
                        input logic start, input logic l);
        chk({tag, ".bip_en"},   {31'd0, bip_en},   {31'd0, en});
        chk({tag, ".bip_rst"},  {31'd0, bip_rst},  {31'd0, rst});
        chk({tag, ".tx_start"}, {31'd0, tx_start}, {31'd0, start});
        chk({tag, ".led"},      {31'd0, led},      {31'd0, l});
    endtask

    task automatic send_cmd(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
    endtask

    // Handshake n frame bytes; the first tx_start must already be visible.
    // With collide set, an rx byte arrives together with the third tx_done.
    task automatic recv(input logic [47:0] frame, input int n, input bit collide);
        for (int i = 0; i < n; i++) begin
            logic [7:0] b;
            b = frame[47 - 8*i -: 8];
            chk($sformatf("byte%0d.tx_start", i), {31'd0, tx_start}, 32'd1);
            chk($sformatf("byte%0d.tx_data", i), {24'd0, tx_data}, {24'd0, b});
            tick();
            chk($sformatf("byte%0d.gap1", i), {31'd0, tx_start}, 32'd0);
            tick();
            chk($sformatf("byte%0d.gap2", i), {31'd0, tx_start}, 32'd0);
            chk($sformatf("byte%0d.hold", i), {24'd0, tx_data}, {24'd0, b});
            tx_done = 1'b1;
            if (collide && (i == 2)) begin
                rx_data = 8'h01;
                rx_done = 1'b1;
            end
            tick();
            tx_done = 1'b0;
            rx_done = 1'b0;
            if (collide && (i == 2)) begin
                chk("collide.bip_rst", {31'd0, bip_rst}, 32'd0);
                chk("collide.led", {31'd0, led}, 32'd0);
            end
        end
        if (n == 6) begin
            outs("frame_end", 1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        reset    = 1'b1;
        rx_done  = 1'b0;
        rx_data  = 8'h00;
        tx_done  = 1'b0;
        bip_halt = 1'b0;
        bip_pc   = 11'h000;
        bip_acc  = 16'h0000;

        // Reset held for three cycles.
        tick(); tick(); tick();
        outs("in_reset", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("in_reset.tx_data", {24'd0, tx_data}, 32'd0);
        reset = 1'b0;
        tick();
        outs("post_reset", 1'b0, 1'b0, 1'b0, 1'b0);

        // RUN: halt on the fifth enabled cycle.
        bip_pc  = 11'h005;
        bip_acc = 16'h0007;
        send_cmd(8'h01);
        outs("run1.rst", 1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        outs("run1.en1", 1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 2; i <= 5; i++) begin
            tick();
            outs($sformatf("run1.en%0d", i), 1'b1, 1'b0, 1'b0, 1'b1);
        end
        bip_halt = 1'b1;
        tick();
        bip_halt = 1'b0;
        outs("run1.snap", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        recv(48'h0005_0007_0005, 6, 1'b0);

        // RST command clears the counter, no reply.
        send_cmd(8'h03);
        outs("rst.pulse", 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        outs("rst.after", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        outs("rst.noreply", 1'b0, 1'b0, 1'b0, 1'b0);

        // Two single steps.
        bip_pc  = 11'h123;
        bip_acc = 16'hBEEF;
        send_cmd(8'h02);
        outs("step1.en", 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        outs("step1.snap", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        recv(48'h0123_BEEF_0001, 6, 1'b0);

        bip_pc   = 11'h7FF;
        bip_acc  = 16'h8001;
        send_cmd(8'h02);
        bip_halt = 1'b1;
        outs("step2.en", 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        bip_halt = 1'b0;
        outs("step2.snap", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        recv(48'h07FF_8001_0002, 6, 1'b0);

        // Unknown byte and stray tx_done in IDLE are ignored.
        send_cmd(8'h55);
        outs("junk.0", 1'b0, 1'b0, 1'b0, 1'b0);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        outs("junk.1", 1'b0, 1'b0, 1'b0, 1'b0);

        // RUN with a second RUN byte and a stray tx_done mid-run.
        bip_pc  = 11'h00A;
        bip_acc = 16'h1234;
        send_cmd(8'h01);
        outs("run2.rst", 1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        outs("run2.en1", 1'b1, 1'b0, 1'b0, 1'b1);
        rx_data = 8'h01;
        rx_done = 1'b1;
        tx_done = 1'b1;
        tick();
        rx_done = 1'b0;
        tx_done = 1'b0;
        outs("run2.en2", 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        outs("run2.en3", 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        outs("run2.en4", 1'b1, 1'b0, 1'b0, 1'b1);
        bip_halt = 1'b1;
        tick();
        bip_halt = 1'b0;
        outs("run2.snap", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        recv(48'h000A_1234_0004, 6, 1'b1);

        // Long run: the counter saturates instead of wrapping.
        bip_pc  = 11'h400;
        bip_acc = 16'h0000;
        send_cmd(8'h01);
        tick();
        repeat (70000) tick();
        outs("sat.running", 1'b1, 1'b0, 1'b0, 1'b1);
        bip_halt = 1'b1;
        tick();
        bip_halt = 1'b0;
        outs("sat.snap", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        recv(48'h0400_0000_FFFF, 6, 1'b0);

        // Reset while waiting on byte 2.
        bip_pc  = 11'h055;
        bip_acc = 16'hAAAA;
        send_cmd(8'h02);
        tick();
        tick();
        recv(48'h0055_AAAA_FFFF, 2, 1'b0);
        chk("abort.byte2.tx_start", {31'd0, tx_start}, 32'd1);
        chk("abort.byte2.tx_data", {24'd0, tx_data}, 32'h0000_00AA);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        outs("abort.reset", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("abort.tx_data", {24'd0, tx_data}, 32'd0);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("abort.quiet%0d", i), {31'd0, tx_start}, 32'd0);
            tick();
        end

        // Counter was cleared by the reset: a step reads back 1.
        bip_pc  = 11'h001;
        bip_acc = 16'h0002;
        send_cmd(8'h02);
        tick();
        tick();
        recv(48'h0001_0002_0001, 6, 1'b0);

        // RUN restarts normally after the abort.
        bip_pc  = 11'h002;
        bip_acc = 16'h0003;
        send_cmd(8'h01);
        outs("run3.rst", 1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        outs("run3.en1", 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        outs("run3.en2", 1'b1, 1'b0, 1'b0, 1'b1);
        bip_halt = 1'b1;
        tick();
        bip_halt = 1'b0;
        outs("run3.snap", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        recv(48'h0002_0003_0002, 6, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
